snn_frame_loader: RTL and testbench
===================================

# snn_frame_loader

Upstream feeder and result collector for the SNN core. Accepts one frame of 85 bytes on a valid/ready byte stream: 4 FC weights, then 9 kernel taps, then 72 image bytes (image A rows 0..5, then image B). It replays the frame onto the SNN input bus in the exact per-cycle alignment the core expects. It then captures the core's one-cycle `out_valid`/`out_data` pulse into a held result register with its own valid/ready handshake.

## Interface
- FRAME_BYTES, 85, bytes per frame (4 weight + 9 kernel + 72 image); fixed, not for override
- IMG_BYTES, 72, length of the SNN in_valid burst
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- s_valid  input  1  upstream byte valid
- s_data  input  8  upstream byte
- s_ready  output  1  loader can accept a byte
- snn_in_valid  output  1  drives SNN in_valid
- snn_img  output  8  drives SNN img
- snn_ker  output  8  drives SNN ker
- snn_weight  output  8  drives SNN weight
- snn_out_valid  input  1  SNN out_valid
- snn_out_data  input  10  SNN out_data
- res_valid  output  1  result held for consumer
- res_data  output  10  captured SNN result
- res_ready  input  1  consumer takes result
- err  output  1  sticky: SNN out_valid seen outside WAIT

## Operation
- Storage: frame buffer of 85 × 8-bit registers. A write index wr_idx[6:0] selects the entry; byte k is written at index k.
- FSM states:
  - LOAD: s_ready=1 while wr_idx<85. A byte is accepted on s_valid&s_ready and increments wr_idx. When wr_idx==85 (frame full), s_ready=0.
  - LOAD→SEND: when frame full and (res_valid==0, or res_valid&res_ready in this cycle). Otherwise the loader holds in LOAD, full, with s_ready=0.
  - SEND: 72 cycles, tx_idx 0..71.
    - snn_in_valid=1.
    - snn_img = buf[13+tx_idx].
    - snn_ker = buf[4+tx_idx] for tx_idx<9, else 0.
    - snn_weight = buf[tx_idx] for tx_idx<4, else 0.
  - SEND→WAIT: after tx_idx==71. wr_idx clears to 0.
  - WAIT: s_ready=0, all snn_* driving outputs 0. Stays until snn_out_valid.
  - WAIT→LOAD: on snn_out_valid. snn_out_data is latched into res_data and res_valid is set.
- Result slot:
  - res_valid clears on res_valid&res_ready.
  - res_data holds its value until the next capture.
- err: set when snn_out_valid=1 in LOAD or SEND. That pulse is ignored (no capture). err is cleared only by rst.
- Outside SEND, snn_in_valid, snn_img, snn_ker and snn_weight are all 0.
- All snn_* outputs, s_ready, res_valid and res_data are registered; no combinational path from s_valid or res_ready to any output.

## Timing
- Reset values:
  - During rst: state=LOAD, wr_idx=0, tx_idx=0, s_ready=0, snn_in_valid=0, snn_img/ker/weight=0, res_valid=0, res_data=0, err=0.
  - First cycle after rst deasserts: s_ready=1.
- Last byte accepted at edge t → snn_in_valid=1 on cycles t+1..t+72, provided the result slot is free. Otherwise the burst starts on the cycle after the slot frees.
- snn_in_valid is never deasserted mid-burst. There is no backpressure in SEND.
- snn_out_valid sampled at edge u in WAIT → res_valid=1 and s_ready=1 from cycle u+1.
- s_valid while s_ready=0: the byte is not consumed, and upstream must hold it.
- rst mid-SEND: the burst aborts immediately with snn_in_valid=0. The buffer contents are discarded (wr_idx=0).
- Simultaneous res_ready and a capture in the same cycle cannot occur: capture happens only in WAIT, and the result slot was already empty on entry to SEND.

## Test plan
- Reset/idle:
  - Stimulus: assert rst for 3 cycles, then release.
  - Required: all outputs 0 during rst; s_ready=1 one cycle after release; snn_in_valid stays 0 with no input.
- Alignment:
  - Stimulus: stream bytes 1..85 back-to-back.
  - Required: snn_in_valid high for exactly 72 cycles.
    - Burst cycles 0..3: weight=1,2,3,4.
    - Burst cycles 0..8: ker=5..13; ker=0 from cycle 9.
    - Burst cycle 0: img=14. Burst cycle 71: img=85.
    - weight=0 from cycle 4.
- Result capture:
  - Stimulus: stub asserts out_valid with out_data=10'h2A, 10 cycles after the burst ends; res_ready=1.
  - Required: res_valid=1, res_data=42 for one cycle; s_ready=1 at the same cycle.
- Slot-full stall:
  - Stimulus: hold res_ready=0; load a second frame.
  - Required: s_ready=0 after byte 85; no burst starts.
    - Assert res_ready → burst starts on the cycle after res_valid clears.
    - res_data=42 is held until that handshake.
- Upstream gaps:
  - Stimulus: s_valid toggles 1/0 every cycle during LOAD.
  - Required: same burst content as the Alignment test; no byte duplicated or dropped.
- Spurious pulse and reset abort:
  - Stimulus 1: snn_out_valid=1 with data 10'h3FF during LOAD. Required: err=1, res_valid unchanged.
  - Stimulus 2: rst at burst cycle 30. Required: snn_in_valid=0 immediately; the next frame loads from byte 0.

Source files
------------

// File: rtl/snn_frame_loader.sv
// snn_frame_loader: buffers one 85-byte frame (4 weights, 9 kernel taps,
// 72 image bytes) from a valid/ready byte stream. It then replays the frame onto
// the SNN input bus as a 72-cycle burst and captures the core's one-cycle
// result pulse into a held result slot with its own valid/ready handshake.
module snn_frame_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       snn_in_valid,
  output logic [7:0] snn_img,
  output logic [7:0] snn_ker,
  output logic [7:0] snn_weight,
  input  logic       snn_out_valid,
  input  logic [9:0] snn_out_data,
  output logic       res_valid,
  output logic [9:0] res_data,
  input  logic       res_ready,
  output logic       err
);

  localparam int FRAME_BYTES = 85;
  localparam int IMG_BYTES   = 72;
  localparam int W_BYTES     = 4;
  localparam int K_BYTES     = 9;
  localparam int IMG_BASE    = W_BYTES + K_BYTES;

  typedef enum logic [1:0] {
    LOAD,
    SEND,
    WAIT
  } state_t;

  state_t     r_state;
  logic [7:0] r_buf [FRAME_BYTES];
  logic [6:0] r_wr_idx;
  logic [6:0] r_tx_idx;
  logic       r_s_ready;
  logic       r_snn_in_valid;
  logic [7:0] r_snn_img;
  logic [7:0] r_snn_ker;
  logic [7:0] r_snn_weight;
  logic       r_res_valid;
  logic [9:0] r_res_data;
  logic       r_err;

  logic       w_accept;
  logic [6:0] w_wr_idx_next;
  logic       w_full_next;
  logic       w_slot_free;
  logic       w_start;
  logic       w_tx_last;
  logic [6:0] w_tx_sel;
  logic [7:0] w_img;
  logic [7:0] w_ker;
  logic [7:0] w_weight;

  // A byte is taken only while loading and while the registered ready is high,
  // so wr_idx saturates at FRAME_BYTES without an explicit bound.
  assign w_accept      = (r_state == LOAD) && s_valid && r_s_ready;
  assign w_wr_idx_next = r_wr_idx + 7'(w_accept);
  assign w_full_next   = (w_wr_idx_next == 7'(FRAME_BYTES));

  // The burst may start on the same edge that takes the last byte, or on the
  // edge that drains a held result, so the first beat appears one cycle later.
  assign w_slot_free = !r_res_valid || res_ready;
  assign w_start     = (r_state == LOAD) && w_full_next && w_slot_free;
  assign w_tx_last   = (r_tx_idx == 7'(IMG_BYTES - 1));

  // Outputs are registered, so the beat loaded at each edge is the next index.
  assign w_tx_sel = w_start ? 7'd0 : r_tx_idx + 7'd1;
  assign w_img    = r_buf[7'(IMG_BASE) + w_tx_sel];
  assign w_ker    = (w_tx_sel < 7'(K_BYTES)) ? r_buf[7'(W_BYTES) + w_tx_sel] : 8'd0;
  assign w_weight = (w_tx_sel < 7'(W_BYTES)) ? r_buf[w_tx_sel] : 8'd0;

  // Frame buffer write port: byte k of the frame lands at index k.
  // NOTE: the buffer has no reset; stale contents are never read because a
  // burst only starts after all 85 entries have been rewritten.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_wr_idx] <= s_data;
    end
  end

  // Control FSM with registered stream, SNN-bus, result and error outputs.
  // NOTE: every register here uses non-blocking assignment so all of them
  // update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= LOAD;
      r_wr_idx       <= 7'd0;
      r_tx_idx       <= 7'd0;
      r_s_ready      <= 1'b0;
      r_snn_in_valid <= 1'b0;
      r_snn_img      <= 8'd0;
      r_snn_ker      <= 8'd0;
      r_snn_weight   <= 8'd0;
      r_res_valid    <= 1'b0;
      r_res_data     <= 10'd0;
      r_err          <= 1'b0;
    end else begin
      if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
      // A result pulse outside WAIT is flagged and otherwise dropped.
      if (snn_out_valid && (r_state != WAIT)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        LOAD: begin
          r_wr_idx <= w_wr_idx_next;
          if (w_start) begin
            r_state        <= SEND;
            r_s_ready      <= 1'b0;
            r_tx_idx       <= 7'd0;
            r_snn_in_valid <= 1'b1;
            r_snn_img      <= w_img;
            r_snn_ker      <= w_ker;
            r_snn_weight   <= w_weight;
          end else begin
            r_s_ready <= !w_full_next;
          end
        end
        SEND: begin
          if (w_tx_last) begin
            r_state        <= WAIT;
            r_wr_idx       <= 7'd0;
            r_tx_idx       <= 7'd0;
            r_snn_in_valid <= 1'b0;
            r_snn_img      <= 8'd0;
            r_snn_ker      <= 8'd0;
            r_snn_weight   <= 8'd0;
          end else begin
            r_tx_idx     <= w_tx_sel;
            r_snn_img    <= w_img;
            r_snn_ker    <= w_ker;
            r_snn_weight <= w_weight;
          end
        end
        WAIT: begin
          if (snn_out_valid) begin
            r_state     <= LOAD;
            r_res_data  <= snn_out_data;
            r_res_valid <= 1'b1;
            r_s_ready   <= 1'b1;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign s_ready      = r_s_ready;
  assign snn_in_valid = r_snn_in_valid;
  assign snn_img      = r_snn_img;
  assign snn_ker      = r_snn_ker;
  assign snn_weight   = r_snn_weight;
  assign res_valid    = r_res_valid;
  assign res_data     = r_res_data;
  assign err          = r_err;

endmodule

// File: tb/tb_snn_frame_loader.sv
// Directed testbench for snn_frame_loader: reset, burst alignment, result
// capture, slot-full stall, upstream gaps, spurious pulse and reset abort.
module tb_snn_frame_loader;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       snn_in_valid;
  logic [7:0] snn_img;
  logic [7:0] snn_ker;
  logic [7:0] snn_weight;
  logic       snn_out_valid;
  logic [9:0] snn_out_data;
  logic       res_valid;
  logic [9:0] res_data;
  logic       res_ready;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  // Captured burst beats
  logic [7:0] b_img [100];
  logic [7:0] b_ker [100];
  logic [7:0] b_wt  [100];
  int         b_len;

  snn_frame_loader dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .snn_in_valid (snn_in_valid),
    .snn_img      (snn_img),
    .snn_ker      (snn_ker),
    .snn_weight   (snn_weight),
    .snn_out_valid(snn_out_valid),
    .snn_out_data (snn_out_data),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_ready    (res_ready),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bus contents for a frame whose byte k equals base+k.
  function automatic logic [7:0] exp_wt(input int base, input int c);
    return (c < 4) ? 8'(base + c) : 8'd0;
  endfunction
  function automatic logic [7:0] exp_ker(input int base, input int c);
    return (c < 9) ? 8'(base + 4 + c) : 8'd0;
  endfunction
  function automatic logic [7:0] exp_img(input int base, input int c);
    return 8'(base + 13 + c);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams bytes base..base+84; with gaps, s_valid drops for one cycle after each byte.
  task automatic send_frame(input int base, input bit gaps);
    int  wait_cnt;
    bit  ready_now;
    for (int k = 0; k < 85; k++) begin
      s_valid   = 1'b1;
      s_data    = 8'(base + k);
      ready_now = 1'b0;
      wait_cnt  = 0;
      while (!ready_now && wait_cnt < 50) begin
        ready_now = s_ready;
        step();
        wait_cnt++;
      end
      if (!ready_now) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: byte %0d not accepted, s_ready=%0b expected 1", k, s_ready);
        s_valid = 1'b0;
        return;
      end
      if (gaps && k < 84) begin
        s_valid = 1'b0;
        step();
      end
    end
    s_valid = 1'b0;
  endtask

  // Records beats while snn_in_valid is high, starting at the current cycle.
  task automatic collect_burst();
    b_len = 0;
    while (snn_in_valid === 1'b1 && b_len < 100) begin
      b_img[b_len] = snn_img;
      b_ker[b_len] = snn_ker;
      b_wt[b_len]  = snn_weight;
      b_len++;
      step();
    end
  endtask

  task automatic pulse_out(input logic [9:0] d);
    snn_out_valid = 1'b1;
    snn_out_data  = d;
    step();
    snn_out_valid = 1'b0;
    snn_out_data  = 10'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks += 8;
    if (s_ready !== 1'b0)      begin n_fail++; $display("FAIL rst_s_ready: got %0b expected 0", s_ready); end
    if (snn_in_valid !== 1'b0) begin n_fail++; $display("FAIL rst_in_valid: got %0b expected 0", snn_in_valid); end
    if (snn_img !== 8'd0)      begin n_fail++; $display("FAIL rst_img: got %0d expected 0", snn_img); end
    if (snn_ker !== 8'd0)      begin n_fail++; $display("FAIL rst_ker: got %0d expected 0", snn_ker); end
    if (snn_weight !== 8'd0)   begin n_fail++; $display("FAIL rst_weight: got %0d expected 0", snn_weight); end
    if (res_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_res_valid: got %0b expected 0", res_valid); end
    if (res_data !== 10'd0)    begin n_fail++; $display("FAIL rst_res_data: got %0d expected 0", res_data); end
    if (err !== 1'b0)          begin n_fail++; $display("FAIL rst_err: got %0b expected 0", err); end
    rst = 1'b0;
    step();
    n_checks++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_s_ready: got %0b expected 1", s_ready); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (snn_in_valid !== 1'b0) begin n_fail++; $display("FAIL idle_in_valid[%0d]: got %0b expected 0", i, snn_in_valid); end
    end
  endtask

  task automatic test_alignment();
    send_frame(1, 1'b0);
    collect_burst();
    n_checks++;
    if (b_len !== 72) begin n_fail++; $display("FAIL align_len: got %0d expected 72", b_len); end
    for (int c = 0; c < 72; c++) begin
      n_checks += 3;
      if (b_wt[c] !== exp_wt(1, c))   begin n_fail++; $display("FAIL align_weight[%0d]: got %0d expected %0d", c, b_wt[c], exp_wt(1, c)); end
      if (b_ker[c] !== exp_ker(1, c)) begin n_fail++; $display("FAIL align_ker[%0d]: got %0d expected %0d", c, b_ker[c], exp_ker(1, c)); end
      if (b_img[c] !== exp_img(1, c)) begin n_fail++; $display("FAIL align_img[%0d]: got %0d expected %0d", c, b_img[c], exp_img(1, c)); end
    end
    n_checks += 4;
    if (s_ready !== 1'b0)    begin n_fail++; $display("FAIL wait_s_ready: got %0b expected 0", s_ready); end
    if (snn_img !== 8'd0)    begin n_fail++; $display("FAIL wait_img: got %0d expected 0", snn_img); end
    if (snn_ker !== 8'd0)    begin n_fail++; $display("FAIL wait_ker: got %0d expected 0", snn_ker); end
    if (snn_weight !== 8'd0) begin n_fail++; $display("FAIL wait_weight: got %0d expected 0", snn_weight); end
  endtask

  task automatic test_capture();
    repeat (9) step();
    res_ready = 1'b1;
    pulse_out(10'h2A);
    n_checks += 3;
    if (res_valid !== 1'b1)  begin n_fail++; $display("FAIL cap_res_valid: got %0b expected 1", res_valid); end
    if (res_data !== 10'd42) begin n_fail++; $display("FAIL cap_res_data: got %0d expected 42", res_data); end
    if (s_ready !== 1'b1)    begin n_fail++; $display("FAIL cap_s_ready: got %0b expected 1", s_ready); end
    step();
    n_checks += 3;
    if (res_valid !== 1'b0)  begin n_fail++; $display("FAIL cap_res_clear: got %0b expected 0", res_valid); end
    if (res_data !== 10'd42) begin n_fail++; $display("FAIL cap_res_hold: got %0d expected 42", res_data); end
    if (err !== 1'b0)        begin n_fail++; $display("FAIL cap_err: got %0b expected 0", err); end
  endtask

  task automatic test_stall();
    res_ready = 1'b0;
    send_frame(1, 1'b0);
    collect_burst();
    n_checks++;
    if (b_len !== 72) begin n_fail++; $display("FAIL stall_first_len: got %0d expected 72", b_len); end
    repeat (3) step();
    pulse_out(10'h2A);
    n_checks++;
    if (res_valid !== 1'b1) begin n_fail++; $display("FAIL stall_res_valid: got %0b expected 1", res_valid); end
    send_frame(21, 1'b0);
    n_checks += 2;
    if (s_ready !== 1'b0)      begin n_fail++; $display("FAIL stall_s_ready: got %0b expected 0", s_ready); end
    if (snn_in_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_burst: got %0b expected 0", snn_in_valid); end
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks += 3;
      if (snn_in_valid !== 1'b0) begin n_fail++; $display("FAIL stall_hold_valid[%0d]: got %0b expected 0", i, snn_in_valid); end
      if (res_valid !== 1'b1)    begin n_fail++; $display("FAIL stall_hold_res[%0d]: got %0b expected 1", i, res_valid); end
      if (res_data !== 10'd42)   begin n_fail++; $display("FAIL stall_hold_data[%0d]: got %0d expected 42", i, res_data); end
    end
    res_ready = 1'b1;
    step();
    n_checks += 2;
    if (res_valid !== 1'b0)    begin n_fail++; $display("FAIL stall_release_res: got %0b expected 0", res_valid); end
    if (snn_in_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release_burst: got %0b expected 1", snn_in_valid); end
    collect_burst();
    n_checks++;
    if (b_len !== 72) begin n_fail++; $display("FAIL stall_len: got %0d expected 72", b_len); end
    for (int c = 0; c < 72; c++) begin
      n_checks += 3;
      if (b_wt[c] !== exp_wt(21, c))   begin n_fail++; $display("FAIL stall_weight[%0d]: got %0d expected %0d", c, b_wt[c], exp_wt(21, c)); end
      if (b_ker[c] !== exp_ker(21, c)) begin n_fail++; $display("FAIL stall_ker[%0d]: got %0d expected %0d", c, b_ker[c], exp_ker(21, c)); end
      if (b_img[c] !== exp_img(21, c)) begin n_fail++; $display("FAIL stall_img[%0d]: got %0d expected %0d", c, b_img[c], exp_img(21, c)); end
    end
    pulse_out(10'h155);
    n_checks += 2;
    if (res_valid !== 1'b1)   begin n_fail++; $display("FAIL stall_cap_valid: got %0b expected 1", res_valid); end
    if (res_data !== 10'h155) begin n_fail++; $display("FAIL stall_cap_data: got %0h expected 155", res_data); end
    step();
  endtask

  task automatic test_gaps();
    send_frame(1, 1'b1);
    collect_burst();
    n_checks++;
    if (b_len !== 72) begin n_fail++; $display("FAIL gaps_len: got %0d expected 72", b_len); end
    for (int c = 0; c < 72; c++) begin
      n_checks += 3;
      if (b_wt[c] !== exp_wt(1, c))   begin n_fail++; $display("FAIL gaps_weight[%0d]: got %0d expected %0d", c, b_wt[c], exp_wt(1, c)); end
      if (b_ker[c] !== exp_ker(1, c)) begin n_fail++; $display("FAIL gaps_ker[%0d]: got %0d expected %0d", c, b_ker[c], exp_ker(1, c)); end
      if (b_img[c] !== exp_img(1, c)) begin n_fail++; $display("FAIL gaps_img[%0d]: got %0d expected %0d", c, b_img[c], exp_img(1, c)); end
    end
    repeat (2) step();
    pulse_out(10'h0C3);
    n_checks++;
    if (res_data !== 10'h0C3) begin n_fail++; $display("FAIL gaps_cap_data: got %0h expected 0c3", res_data); end
    step();
  endtask

  task automatic test_spurious();
    pulse_out(10'h3FF);
    n_checks += 4;
    if (err !== 1'b1)         begin n_fail++; $display("FAIL spur_err: got %0b expected 1", err); end
    if (res_valid !== 1'b0)   begin n_fail++; $display("FAIL spur_res_valid: got %0b expected 0", res_valid); end
    if (res_data !== 10'h0C3) begin n_fail++; $display("FAIL spur_res_data: got %0h expected 0c3", res_data); end
    if (s_ready !== 1'b1)     begin n_fail++; $display("FAIL spur_s_ready: got %0b expected 1", s_ready); end
    repeat (3) step();
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL spur_err_sticky: got %0b expected 1", err); end
  endtask

  task automatic test_reset_abort();
    send_frame(1, 1'b0);
    repeat (30) step();
    n_checks++;
    if (snn_in_valid !== 1'b1) begin n_fail++; $display("FAIL abort_mid_burst: got %0b expected 1", snn_in_valid); end
    rst = 1'b1;
    #1;
    n_checks += 4;
    if (snn_in_valid !== 1'b0) begin n_fail++; $display("FAIL abort_in_valid: got %0b expected 0", snn_in_valid); end
    if (snn_img !== 8'd0)      begin n_fail++; $display("FAIL abort_img: got %0d expected 0", snn_img); end
    if (err !== 1'b0)          begin n_fail++; $display("FAIL abort_err: got %0b expected 0", err); end
    if (res_data !== 10'd0)    begin n_fail++; $display("FAIL abort_res_data: got %0d expected 0", res_data); end
    repeat (2) step();
    rst = 1'b0;
    step();
    n_checks++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL abort_s_ready: got %0b expected 1", s_ready); end
    send_frame(101, 1'b0);
    collect_burst();
    n_checks++;
    if (b_len !== 72) begin n_fail++; $display("FAIL abort_len: got %0d expected 72", b_len); end
    for (int c = 0; c < 72; c++) begin
      n_checks += 3;
      if (b_wt[c] !== exp_wt(101, c))   begin n_fail++; $display("FAIL abort_weight[%0d]: got %0d expected %0d", c, b_wt[c], exp_wt(101, c)); end
      if (b_ker[c] !== exp_ker(101, c)) begin n_fail++; $display("FAIL abort_ker[%0d]: got %0d expected %0d", c, b_ker[c], exp_ker(101, c)); end
      if (b_img[c] !== exp_img(101, c)) begin n_fail++; $display("FAIL abort_img[%0d]: got %0d expected %0d", c, b_img[c], exp_img(101, c)); end
    end
  endtask

  initial begin
    rst           = 1'b1;
    s_valid       = 1'b0;
    s_data        = 8'd0;
    snn_out_valid = 1'b0;
    snn_out_data  = 10'd0;
    res_ready     = 1'b0;
    test_reset();
    test_alignment();
    test_capture();
    test_stall();
    test_gaps();
    test_spurious();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so a stuck DUT cannot hang the run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
